// File: rtl/port_mux_cfg_if.sv
// port_mux_cfg_if -- register access bus for the port mux configuration block.
//
// Signals:
//   cfg_sel   : single-cycle access strobe
//   cfg_we    : write enable, qualifies cfg_sel
//   cfg_addr  : register word index (0..3)
//   cfg_wdata : write data
//   cfg_rdata : registered read data, valid the cycle after a read strobe
//
// Modports: master drives the access, slave (the block) returns cfg_rdata.
interface port_mux_cfg_if;
  logic        cfg_sel;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_sel,
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_sel,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/port_mux_cfg.sv
// port_mux_cfg -- pad function multiplexer for a bank of PA_WIDTH pads.
//
// Each pad is routed to GPIO, to the UART (as TX or RX pad), or disabled,
// under control of a small register file. Pad inputs are synchronised and,
// optionally, glitch filtered before they reach GPIO, UART or PINSTAT.
//
// Registers (word index):
//   0 FUNCSEL : 2 bits per pad, 00 GPIO, 01 UART, 10/11 disabled
//   1 UARTPIN : [3:0] RX pad index, [11:8] TX pad index
//   2 PINSTAT : read-only conditioned pad inputs
//   3         : reads 0
//
// Ports:
//   clk_in, rst_n                 : clock, asynchronous active-low reset
//   cfg                           : register access bus (slave modport)
//   pad_pmux_din                  : raw pad inputs
//   pmux_pad_ie/oe/dout           : pad input enable, output enable, output data
//   gpio_pad_out, gpio_pad_oe     : GPIO output data / enables
//   pad_gpio_in                   : conditioned pad inputs to GPIO
//   uart_pad_tx, pad_uart_rx      : UART transmit in, receive out
//
// Build option: define PORT_MUX_FILTER_EN to insert a FILT_LEN-cycle
// stability filter after the synchroniser.
module port_mux_cfg #(
  parameter int PA_WIDTH = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  port_mux_cfg_if.slave       cfg,
  input  logic [PA_WIDTH-1:0] pad_pmux_din,
  output logic [PA_WIDTH-1:0] pmux_pad_ie,
  output logic [PA_WIDTH-1:0] pmux_pad_oe,
  output logic [PA_WIDTH-1:0] pmux_pad_dout,
  input  logic [PA_WIDTH-1:0] gpio_pad_out,
  input  logic [PA_WIDTH-1:0] gpio_pad_oe,
  output logic [PA_WIDTH-1:0] pad_gpio_in,
  input  logic                uart_pad_tx,
  output logic                pad_uart_rx
);

  if (PA_WIDTH < 2 || PA_WIDTH > 16 || FILT_LEN < 2 || FILT_LEN > 15) begin : g_param_check
    $error("port_mux_cfg: PA_WIDTH or FILT_LEN out of range");
  end

  logic [2*PA_WIDTH-1:0] funcsel;
  logic [3:0]            rx_idx;
  logic [3:0]            tx_idx;
  logic [PA_WIDTH-1:0]   sync_p0;
  logic [PA_WIDTH-1:0]   sync_p1;
  logic [PA_WIDTH-1:0]   cond;
  logic [31:0]           rd_mux;
  logic                  wdata_unused;

  // Upper write-data bits are architecturally ignored for some registers.
  assign wdata_unused = ^cfg.cfg_wdata;

  always_comb begin
    rd_mux = '0;
    case (cfg.cfg_addr)
      2'd0:    rd_mux[2*PA_WIDTH-1:0] = funcsel;
      2'd1:    rd_mux[11:0] = {tx_idx, 4'b0000, rx_idx};
      2'd2:    rd_mux[PA_WIDTH-1:0] = cond;
      default: rd_mux = '0;
    endcase
  end

  // Register file and registered read port
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      funcsel       <= '0;
      rx_idx        <= '0;
      tx_idx        <= '0;
      cfg.cfg_rdata <= '0;
    end else if (cfg.cfg_sel) begin
      if (cfg.cfg_we) begin
        case (cfg.cfg_addr)
          2'd0: funcsel <= cfg.cfg_wdata[2*PA_WIDTH-1:0];
          2'd1: begin
            rx_idx <= cfg.cfg_wdata[3:0];
            tx_idx <= cfg.cfg_wdata[11:8];
          end
          default: ;
        endcase
      end else begin
        cfg.cfg_rdata <= rd_mux;
      end
    end
  end

  // Stage p0/p1: two-flop input synchroniser
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pad_pmux_din;
      sync_p1 <= sync_p0;
    end
  end

`ifdef PORT_MUX_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [PA_WIDTH-1:0] filt_p2;
  logic [3:0]          filt_cnt [PA_WIDTH];

  // Stage p2: the filtered value only follows the synchroniser once the two
  // have disagreed for FILT_LEN consecutive cycles; agreement restarts the run.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      filt_p2 <= '0;
      for (int i = 0; i < PA_WIDTH; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PA_WIDTH; i++) begin
        if (sync_p1[i] != filt_p2[i]) begin
          if (filt_cnt[i] == FILT_LAST) begin
            filt_p2[i]  <= sync_p1[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 4'd1;
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end

  assign cond = filt_p2;
`else
  assign cond = sync_p1;
`endif

  // Pad routing. TX wins when TX and RX name the same pad, and an index that
  // matches no pad in UART mode simply leaves RX idle high.
  always_comb begin
    pmux_pad_ie   = '0;
    pmux_pad_oe   = '0;
    pmux_pad_dout = '0;
    pad_gpio_in   = '0;
    pad_uart_rx   = 1'b1;
    for (int i = 0; i < PA_WIDTH; i++) begin
      case (funcsel[2*i +: 2])
        2'b00: begin
          pmux_pad_ie[i]   = 1'b1;
          pmux_pad_oe[i]   = gpio_pad_oe[i];
          pmux_pad_dout[i] = gpio_pad_out[i];
          pad_gpio_in[i]   = cond[i];
        end
        2'b01: begin
          if (tx_idx == 4'(i)) begin
            pmux_pad_oe[i]   = 1'b1;
            pmux_pad_dout[i] = uart_pad_tx;
          end else if (rx_idx == 4'(i)) begin
            pmux_pad_ie[i] = 1'b1;
            pad_gpio_in[i] = cond[i];
            pad_uart_rx    = cond[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_port_mux_cfg.sv
module tb_port_mux_cfg;
  localparam int PA = 16;
  localparam int FL = 4;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [PA-1:0] pad_pmux_din = '0;
  logic [PA-1:0] gpio_pad_out = '0;
  logic [PA-1:0] gpio_pad_oe  = '0;
  logic          uart_pad_tx  = 1'b1;
  logic [PA-1:0] pmux_pad_ie, pmux_pad_oe, pmux_pad_dout, pad_gpio_in;
  logic          pad_uart_rx;

  port_mux_cfg_if cfg_bus ();

  port_mux_cfg #(.PA_WIDTH(PA), .FILT_LEN(FL)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .cfg          (cfg_bus),
    .pad_pmux_din (pad_pmux_din),
    .pmux_pad_ie  (pmux_pad_ie),
    .pmux_pad_oe  (pmux_pad_oe),
    .pmux_pad_dout(pmux_pad_dout),
    .gpio_pad_out (gpio_pad_out),
    .gpio_pad_oe  (gpio_pad_oe),
    .pad_gpio_in  (pad_gpio_in),
    .uart_pad_tx  (uart_pad_tx),
    .pad_uart_rx  (pad_uart_rx)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents, a two-sample delay line for the
  // synchroniser, and a history of synchronised samples for the filter.
  logic [31:0]   m_funcsel;
  logic [3:0]    m_rx, m_tx;
  logic [PA-1:0] m_s0, m_s1, m_filt;
  logic [PA-1:0] m_hist [FL];
  logic [31:0]   m_rdata;

  function automatic logic [PA-1:0] m_cond();
`ifdef PORT_MUX_FILTER_EN
    return m_filt;
`else
    return m_s1;
`endif
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_funcsel = '0; m_rx = '0; m_tx = '0;
      m_s0 = '0; m_s1 = '0; m_filt = '0; m_rdata = '0;
      for (int k = 0; k < FL; k++) m_hist[k] = '0;
    end else begin
      if (cfg_bus.cfg_sel && !cfg_bus.cfg_we) begin
        case (cfg_bus.cfg_addr)
          2'd0:    m_rdata = m_funcsel;
          2'd1:    m_rdata = {20'd0, m_tx, 4'd0, m_rx};
          2'd2:    m_rdata = {16'd0, m_cond()};
          default: m_rdata = 32'd0;
        endcase
      end
      if (cfg_bus.cfg_sel && cfg_bus.cfg_we) begin
        if (cfg_bus.cfg_addr == 2'd0) m_funcsel = cfg_bus.cfg_wdata;
        if (cfg_bus.cfg_addr == 2'd1) begin
          m_rx = cfg_bus.cfg_wdata[3:0];
          m_tx = cfg_bus.cfg_wdata[11:8];
        end
      end
      // filter: adopt a value once the last FL synchronised samples all hold it
      for (int k = FL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s1;
      for (int i = 0; i < PA; i++) begin
        int ones;
        ones = 0;
        for (int k = 0; k < FL; k++) ones += int'(m_hist[k][i]);
        if (ones == FL) m_filt[i] = 1'b1;
        else if (ones == 0) m_filt[i] = 1'b0;
      end
      m_s1 = m_s0;
      m_s0 = pad_pmux_din;
    end
  end

  task automatic check_all();
    logic [PA-1:0] c, e_ie, e_oe, e_do, e_gi;
    logic          e_rx;
    int            txp, rxp;
    c = m_cond();
    e_ie = '0; e_oe = '0; e_do = '0; e_gi = '0;
    txp = -1; rxp = -1;
    if (int'(m_tx) < PA && m_funcsel[2*m_tx +: 2] == 2'b01) txp = int'(m_tx);
    if (int'(m_rx) < PA && m_funcsel[2*m_rx +: 2] == 2'b01 && m_rx != m_tx) rxp = int'(m_rx);
    for (int i = 0; i < PA; i++) begin
      if (m_funcsel[2*i +: 2] == 2'b00) begin
        e_ie[i] = 1'b1; e_oe[i] = gpio_pad_oe[i]; e_do[i] = gpio_pad_out[i]; e_gi[i] = c[i];
      end else if (i == txp) begin
        e_oe[i] = 1'b1; e_do[i] = uart_pad_tx;
      end else if (i == rxp) begin
        e_ie[i] = 1'b1; e_gi[i] = c[i];
      end
    end
    e_rx = (rxp >= 0) ? c[rxp] : 1'b1;
    chk("ie",      32'(pmux_pad_ie),   32'(e_ie));
    chk("oe",      32'(pmux_pad_oe),   32'(e_oe));
    chk("dout",    32'(pmux_pad_dout), 32'(e_do));
    chk("gpio_in", 32'(pad_gpio_in),   32'(e_gi));
    chk("uart_rx", 32'(pad_uart_rx),   32'(e_rx));
    chk("rdata",   cfg_bus.cfg_rdata,  m_rdata);
  endtask

  always @(negedge clk_in) if (chk_on) check_all();

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b1; cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_wdata = d;
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b0; cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a);
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b1; cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = a;
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    cfg_bus.cfg_sel = 1'b0; cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_addr = '0; cfg_bus.cfg_wdata = '0;
    gpio_pad_out = 16'h3C5A; gpio_pad_oe = 16'h0FF0;
    wait_cycles(3);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // reset state
    cfg_read(2'd0);
    @(negedge clk_in);
    chk("rst_rdata", cfg_bus.cfg_rdata, 32'h0);
    chk("rst_ie", 32'(pmux_pad_ie), 32'h0000FFFF);
    chk("rst_oe", 32'(pmux_pad_oe), 32'(gpio_pad_oe));
    chk("rst_rx", 32'(pad_uart_rx), 32'h1);

    // UART on pads 0 (RX) and 1 (TX)
    pad_pmux_din = '1;
    cfg_write(2'd0, 32'h0000_0005);
    cfg_write(2'd1, 32'h0000_0100);
    uart_pad_tx = 1'b0;
    wait_cycles(FL + 4);
    chk("tx_oe1",   32'(pmux_pad_oe[1]),   32'h1);
    chk("tx_dout1", 32'(pmux_pad_dout[1]), 32'h0);
    chk("rx_idle",  32'(pad_uart_rx),      32'h1);
    pad_pmux_din[0] = 1'b0;
    wait_cycles(FL + 4);
    chk("rx_low", 32'(pad_uart_rx), 32'h0);

    // UARTPIN reserved bits read 0
    cfg_write(2'd1, 32'hFFFF_FFFF);
    cfg_read(2'd1);
    @(negedge clk_in);
    chk("uartpin_rd", cfg_bus.cfg_rdata, 32'h0000_0F0F);

    // pad 15 disabled
    gpio_pad_out = 16'hFFFF;
    cfg_write(2'd0, 32'hC000_0000);
    @(negedge clk_in);
    chk("p15_ie",   32'(pmux_pad_ie[15]),   32'h0);
    chk("p15_oe",   32'(pmux_pad_oe[15]),   32'h0);
    chk("p15_dout", 32'(pmux_pad_dout[15]), 32'h0);
    chk("p15_gin",  32'(pad_gpio_in[15]),   32'h0);

    // TX and RX on the same pad: TX wins, RX idles
    cfg_write(2'd0, 32'h0000_0400);
    cfg_write(2'd1, 32'h0000_0505);
    uart_pad_tx = 1'b1;
    @(negedge clk_in);
    chk("p5_oe", 32'(pmux_pad_oe[5]), 32'h1);
    chk("p5_ie", 32'(pmux_pad_ie[5]), 32'h0);
    chk("p5_rx", 32'(pad_uart_rx),    32'h1);

    // read-only and unused registers ignore writes
    cfg_write(2'd3, 32'hDEAD_BEEF);
    cfg_read(2'd3);
    @(negedge clk_in);
    chk("reg3_rd", cfg_bus.cfg_rdata, 32'h0);

    // glitch filter: short and long pulses on pad 2 in GPIO mode
    cfg_write(2'd0, 32'h0000_0000);
    pad_pmux_din = '0;
    wait_cycles(FL + 4);
    pad_pmux_din[2] = 1'b1;
    wait_cycles(3);
    pad_pmux_din[2] = 1'b0;
    seen = 1'b0;
    repeat (FL + 6) begin
      @(negedge clk_in);
      seen = seen | pad_gpio_in[2];
    end
`ifdef PORT_MUX_FILTER_EN
    chk("filt_short", 32'(seen), 32'h0);
`else
    chk("filt_short", 32'(seen), 32'h1);
`endif
    #1;
    pad_pmux_din[2] = 1'b1;
    wait_cycles(6);
    pad_pmux_din[2] = 1'b0;
    seen = 1'b0;
    repeat (FL + 6) begin
      @(negedge clk_in);
      seen = seen | pad_gpio_in[2];
    end
    chk("filt_long", 32'(seen), 32'h1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      @(posedge clk_in); #1;
      pad_pmux_din = pad_pmux_din ^ PA'($urandom & $urandom & $urandom);
      gpio_pad_out = PA'($urandom);
      gpio_pad_oe  = PA'($urandom);
      uart_pad_tx  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cfg_bus.cfg_sel   = 1'b1;
        cfg_bus.cfg_we    = 1'($urandom);
        cfg_bus.cfg_addr  = 2'($urandom);
        cfg_bus.cfg_wdata = ($urandom_range(0, 1) == 0) ? 32'h5555_5555 & $urandom : $urandom;
      end else begin
        cfg_bus.cfg_sel = 1'b0;
      end
    end
    #1;
    cfg_bus.cfg_sel = 1'b0;

    // reset during a write aborts it
    cfg_write(2'd0, 32'hA5A5_A5A5);
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b1; cfg_bus.cfg_we = 1'b1;
    cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_wdata = 32'hFFFF_0000;
    #2 rst_n = 1'b0;
    @(posedge clk_in); #1;
    cfg_bus.cfg_sel = 1'b0; cfg_bus.cfg_we = 1'b0;
    #2 rst_n = 1'b1;
    cfg_read(2'd0);
    @(negedge clk_in);
    chk("rst_abort", cfg_bus.cfg_rdata, 32'h0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
